// File: rtl/gpu_fill_engine_if.sv
// rtl/gpu_fill_engine_if.sv - block write bus between the fill engine and the VRAM write path
interface gpu_fill_engine_if;
  logic        o_writeValid;
  logic        i_writeReady;
  logic [6:0]  o_writeBlkX;
  logic [8:0]  o_writeY;
  logic [15:0] o_writeColor;

  modport master (
    output o_writeValid,
    output o_writeBlkX,
    output o_writeY,
    output o_writeColor,
    input  i_writeReady
  );

  modport slave (
    input  o_writeValid,
    input  o_writeBlkX,
    input  o_writeY,
    input  o_writeColor,
    output i_writeReady
  );
endinterface

// File: rtl/gpu_fill_engine.sv
// rtl/gpu_fill_engine.sv - VRAM rectangle fill, one 8-pixel block write per handshake
// Optional GPU_FILL_WRAP_EN: wrap at the VRAM edge instead of clipping.
module gpu_fill_engine (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_activate,
  input  logic [9:0]               i_posX,
  input  logic [8:0]               i_posY,
  input  logic [9:0]               i_sizeW,
  input  logic [8:0]               i_sizeH,
  input  logic [15:0]              i_color,
  output logic                     o_busy,
  output logic                     o_inactiveNextCycle,
  gpu_fill_engine_if.master        wr
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL} state_e;

  state_e      state_q, state_d;
  logic [6:0]  blk0_q, blk0_d;
  logic [6:0]  blk_q, blk_d;
  logic [8:0]  y_q, y_d;
  logic [7:0]  rowblk_q, rowblk_d;
  logic [8:0]  h_q, h_d;
  logic [15:0] color_q, color_d;
  logic [7:0]  cols_q, cols_d;
  logic [7:0]  col_left_q, col_left_d;
  logic [9:0]  rows_left_q, rows_left_d;

  logic [10:0] w_aligned;
  logic [7:0]  eff_cols;
  logic [9:0]  eff_rows;
  logic        valid_c;
  logic        inactive_c;

  assign w_aligned = ({1'b0, i_sizeW} + 11'd15) & 11'h7F0;

`ifdef GPU_FILL_WRAP_EN
  assign eff_cols = rowblk_q;
  assign eff_rows = {1'b0, h_q};
`else
  // Out-of-range blocks only ever sit at the end of a row (or of the fill), so
  // clipping reduces to shortening the per-row and row counts up front.
  logic [7:0] room_cols;
  logic [9:0] room_rows;
  assign room_cols = 8'd128 - {1'b0, blk0_q};
  assign room_rows = 10'd512 - {1'b0, y_q};
  assign eff_cols  = (rowblk_q < room_cols) ? rowblk_q : room_cols;
  assign eff_rows  = ({1'b0, h_q} < room_rows) ? {1'b0, h_q} : room_rows;
`endif

  always_comb begin
    state_d     = state_q;
    blk0_d      = blk0_q;
    blk_d       = blk_q;
    y_d         = y_q;
    rowblk_d    = rowblk_q;
    h_d         = h_q;
    color_d     = color_q;
    cols_d      = cols_q;
    col_left_d  = col_left_q;
    rows_left_d = rows_left_q;
    valid_c     = 1'b0;
    inactive_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_activate) begin
          blk0_d   = {i_posX[9:4], 1'b0};
          blk_d    = {i_posX[9:4], 1'b0};
          y_d      = i_posY;
          rowblk_d = w_aligned[10:3];
          h_d      = i_sizeH;
          color_d  = i_color;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cols_d      = eff_cols;
        col_left_d  = eff_cols;
        rows_left_d = eff_rows;
        if (eff_cols == 8'd0 || eff_rows == 10'd0) begin
          inactive_c = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      FILL: begin
        valid_c = 1'b1;
        if (wr.i_writeReady) begin
          if (col_left_q == 8'd1) begin
            if (rows_left_q == 10'd1) begin
              inactive_c = 1'b1;
              state_d    = IDLE;
            end else begin
              blk_d       = blk0_q;
              y_d         = y_q + 9'd1;
              col_left_d  = cols_q;
              rows_left_d = rows_left_q - 10'd1;
            end
          end else begin
            blk_d      = blk_q + 7'd1;
            col_left_d = col_left_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      blk0_q      <= '0;
      blk_q       <= '0;
      y_q         <= '0;
      rowblk_q    <= '0;
      h_q         <= '0;
      color_q     <= '0;
      cols_q      <= '0;
      col_left_q  <= '0;
      rows_left_q <= '0;
    end else begin
      state_q     <= state_d;
      blk0_q      <= blk0_d;
      blk_q       <= blk_d;
      y_q         <= y_d;
      rowblk_q    <= rowblk_d;
      h_q         <= h_d;
      color_q     <= color_d;
      cols_q      <= cols_d;
      col_left_q  <= col_left_d;
      rows_left_q <= rows_left_d;
    end
  end

  // A reset arriving in the final cycle cancels the completion hint.
  assign o_inactiveNextCycle = inactive_c & ~i_rst;
  assign o_busy              = (state_q != IDLE);
  assign wr.o_writeValid     = valid_c;
  assign wr.o_writeBlkX      = blk_q;
  assign wr.o_writeY         = y_q;
  assign wr.o_writeColor     = color_q;

endmodule

// File: tb/tb_gpu_fill_engine.sv
// tb/tb_gpu_fill_engine.sv - randomized self-checking bench for gpu_fill_engine
module tb_gpu_fill_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        activate;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic [9:0]  size_w;
  logic [8:0]  size_h;
  logic [15:0] color;
  logic        busy;
  logic        inact;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  gpu_fill_engine_if wr_if ();

  gpu_fill_engine dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_activate          (activate),
    .i_posX              (pos_x),
    .i_posY              (pos_y),
    .i_sizeW             (size_w),
    .i_sizeH             (size_h),
    .i_color             (color),
    .o_busy              (busy),
    .o_inactiveNextCycle (inact),
    .wr                  (wr_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected block sequence from the fill rules, as {blk[6:0], row[8:0]}.
  task automatic build_model(input int x, input int y, input int w, input int h);
    int x0, wa, nb, row, col;
    exp_q.delete();
    x0 = x & 'h3F0;
    wa = (w + 15) & 'h7F0;
    nb = wa / 8;
    for (int r = 0; r < h; r++) begin
      row = y + r;
`ifdef GPU_FILL_WRAP_EN
      row = row % 512;
`else
      if (row >= 512) break;
`endif
      for (int c = 0; c < nb; c++) begin
        col = x0 / 8 + c;
`ifdef GPU_FILL_WRAP_EN
        col = col % 128;
`else
        if (col >= 128) continue;
`endif
        exp_q.push_back({col[6:0], row[8:0]});
      end
    end
  endtask

  // mode: 0 ready high, 1 pattern 1,0,0,1, 2 random. rst_after>0 resets after that many transfers.
  task automatic run_fill(input int x, input int y, input int w, input int h,
                          input logic [15:0] col, input int mode, input int rst_after, input bit pulse);
    int busy_cycles, xfers, cyc, nexp;
    bit done, popped;
    logic [15:0] head;
    busy_cycles = 0;
    xfers = 0;
    cyc = 0;
    done = 0;
    build_model(x, y, w, h);
    nexp = exp_q.size();
    activate = 1'b1;
    pos_x = x[9:0];
    pos_y = y[8:0];
    size_w = w[9:0];
    size_h = h[8:0];
    color = col;
    wr_if.i_writeReady = 1'b0;
    #1;
    check("idle_busy", busy, 0);
    check("idle_valid", wr_if.o_writeValid, 0);
    @(posedge clk); #1;
    activate = 1'b0;
    pos_x = 10'($urandom);
    pos_y = 9'($urandom);
    size_w = 10'($urandom);
    size_h = 9'($urandom);
    color = 16'($urandom);
    #1;
    check("setup_busy", busy, 1);
    check("setup_valid", wr_if.o_writeValid, 0);
    check("setup_inact", inact, (nexp == 0));
    busy_cycles = 1;
    while (!done) begin
      @(posedge clk); #1;
      if (rst_after > 0 && xfers == rst_after) begin
        rst = 1'b1;
        activate = 1'b0;
        #1;
        check("rst_inact", inact, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wr_if.i_writeReady = 1'b0;
        #1;
        check("rst_valid", wr_if.o_writeValid, 0);
        check("rst_busy", busy, 0);
        exp_q.delete();
        return;
      end
      case (mode)
        0:       wr_if.i_writeReady = 1'b1;
        1:       wr_if.i_writeReady = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: wr_if.i_writeReady = 1'($urandom);
      endcase
      activate = pulse && (exp_q.size() > 0) && ($urandom_range(0, 3) == 0);
      if (activate) begin
        pos_x = 10'($urandom);
        pos_y = 9'($urandom);
        size_w = 10'($urandom);
        size_h = 9'($urandom);
        color = 16'($urandom);
      end
      #1;
      cyc++;
      popped = 0;
      if (!busy) begin
        done = 1;
        check("drain", exp_q.size(), 0);
      end else if (cyc > 4000) begin
        done = 1;
        check("timeout", 1, 0);
      end else begin
        busy_cycles++;
        check("valid", wr_if.o_writeValid, 1);
        head = (exp_q.size() > 0) ? exp_q[0] : 16'hFFFF;
        check("blk", wr_if.o_writeBlkX, head[15:9]);
        check("row", wr_if.o_writeY, head[8:0]);
        check("color", wr_if.o_writeColor, col);
        if (wr_if.i_writeReady) begin
          xfers++;
          if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            popped = 1;
          end
        end
        check("inact", inact, popped && (exp_q.size() == 0));
      end
    end
    activate = 1'b0;
    if (mode == 0) check("busy_cycles", busy_cycles, 1 + nexp);
  endtask

  initial begin
    rst = 1'b1;
    activate = 1'b0;
    pos_x = '0;
    pos_y = '0;
    size_w = '0;
    size_h = '0;
    color = '0;
    wr_if.i_writeReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy0", busy, 0);
    check("rst_valid0", wr_if.o_writeValid, 0);
    check("rst_inact0", inact, 0);
    check("rst_blk0", wr_if.o_writeBlkX, 0);
    check("rst_row0", wr_if.o_writeY, 0);
    check("rst_color0", wr_if.o_writeColor, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_fill('h13, 4, 'h11, 2, 16'h7C1F, 0, 0, 0);
    run_fill('h55, 100, 0, 10, 16'h1234, 0, 0, 0);
    run_fill('h13, 4, 'h11, 2, 16'h7C1F, 1, 0, 0);
    run_fill('h3F0, 511, 'h20, 2, 16'h03E0, 0, 0, 0);
    run_fill(0, 7, 'h3FF, 1, 16'h5555, 0, 0, 0);
    run_fill('h13, 4, 'h11, 2, 16'h7C1F, 0, 3, 0);
    run_fill('h13, 4, 'h11, 2, 16'h7C1F, 0, 0, 0);
    run_fill('h40, 20, 'h50, 3, 16'h2AAA, 2, 0, 1);
    run_fill('h100, 3, 'h10, 0, 16'h0001, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      run_fill($urandom_range(0, 'h3FF), $urandom_range(0, 511), $urandom_range(0, 'h3FF),
               $urandom_range(0, 3), 16'($urandom), $urandom_range(0, 2), 0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpu_fill_engine.md
# gpu_fill_engine

Executes the VRAM rectangle-fill primitive (GP0 0x02) once the work dispatcher issues the fill render start. It sits directly downstream of the dispatcher, alongside the stencil cache. It walks the aligned rectangle row by row and emits one 8-pixel block write per handshake to the memory write path. It signals completion one cycle early so the dispatcher can return to idle without a bubble.

## Interface
Parameters:
- none; block geometry is fixed (VRAM 1024x512, 8 pixels per block)

Ports (synchronous, active-high reset; one clock):
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_activate  in  1  single-cycle pulse; dispatcher issued the fill render start
- i_posX  in  10  fill X; sampled on i_activate
- i_posY  in  9  fill Y; sampled on i_activate
- i_sizeW  in  10  fill width; sampled on i_activate
- i_sizeH  in  9  fill height; sampled on i_activate
- i_color  in  16  fill pixel, already BGR555 with mask bit 0; sampled on i_activate
- o_busy  out  1  high from the cycle after the accepted i_activate until return to IDLE
- o_inactiveNextCycle  out  1  combinational; high in the last busy cycle
- o_writeValid  out  1  block write request
- i_writeReady  in  1  write path accepts the block (transfer = valid & ready)
- o_writeBlkX  out  7  block column (pixel X >> 3)
- o_writeY  out  9  pixel row
- o_writeColor  out  16  pixel value replicated over all 8 pixels of the block

## Operation
- Alignment on capture:
  - x0 = i_posX & 0x3F0.
  - w = (i_sizeW + 15) & 0x7F0, an 11-bit value with maximum 0x400.
  - Block count per row = w >> 3, from 0 to 128.
  - h = i_sizeH, from 0 to 511.
- States: IDLE, SETUP, FILL.
  - IDLE: o_busy=0, o_writeValid=0.
    - i_activate → latch the inputs, go to SETUP.
  - SETUP: one cycle. Load column and row counters; current block = x0>>3, row = i_posY.
    - w==0 or h==0 → o_inactiveNextCycle=1, go to IDLE. No writes are issued.
    - Otherwise → go to FILL.
  - FILL: o_writeValid=1. On each transfer, advance the column.
    - At the last column, reset the column to x0>>3 and increment the row.
    - On the last transfer of the last row: o_inactiveNextCycle=1, go to IDLE.
- While o_writeValid=0 → o_writeBlkX, o_writeY and o_writeColor are don't-care.
- While o_writeValid=1 and there is no transfer → all write outputs are held stable.
- i_activate while not in IDLE is ignored and has no effect on the latched values.
- Block order is row-major: left to right, then top to bottom.

## Timing
- Reset values:
  - o_busy=0, o_writeValid=0, o_inactiveNextCycle=0, state=IDLE.
  - o_writeBlkX=0, o_writeY=0, o_writeColor=0.
- Reset mid-fill → IDLE on the next edge. No further writes. o_inactiveNextCycle is not asserted.
- Latency: i_activate at cycle N → SETUP at N+1 → first o_writeValid at N+2.
- Throughput: with i_writeReady held high, one block per cycle. Busy cycles = 1 + rowBlocks*h.
- Empty fill: o_busy is high for exactly one cycle (SETUP), with o_inactiveNextCycle high in that same cycle.
- A new i_activate is accepted in the first IDLE cycle after completion, i.e. back-to-back with one cycle in IDLE.

## Configuration
- GPU_FILL_WRAP_EN defined:
  - Column wraps modulo 128 blocks and row wraps modulo 512.
  - This matches hardware: a fill crossing the VRAM edge continues at 0.
- GPU_FILL_WRAP_EN undefined:
  - Blocks with column ≥128 are skipped. The skipped blocks produce no write and take no cycle; the row steps to its next in-range block.
  - Rows ≥512 terminate the fill. o_inactiveNextCycle is asserted in the last in-range transfer cycle, or in SETUP if nothing is in range.

## Test plan
- Basic fill:
  - Stimulus: activate X=0x13, Y=4, W=0x11, H=2, color=0x7C1F, ready=1.
  - Response: x0=0x10, w=0x20, so 4 blocks per row.
  - Writes (blk,Y) = (2,4),(3,4),(4,4),(5,4),(2,5),(3,5),(4,5),(5,5), with the first at N+2.
  - o_inactiveNextCycle high on the 8th transfer cycle only.
- Empty fill:
  - Stimulus: W=0, H=10.
  - Response: no o_writeValid; o_busy and o_inactiveNextCycle high for exactly cycle N+1.
- Backpressure:
  - Stimulus: same as the basic fill; ready toggles 1,0,0,1,…
  - Response: outputs are held during ready=0, and the same 8 writes occur in the same order.
- Wrap:
  - Stimulus: X=0x3F0, Y=511, W=0x20, H=2.
  - With the macro: writes (126,511),(127,511),(0,511),(1,511),(126,0),(127,0),(0,0),(1,0).
  - Without the macro: writes (126,511),(127,511), then done.
- Max width:
  - Stimulus: W=0x3FF, H=1.
  - Response: w=0x400, exactly 128 writes.
- Reset and re-activation:
  - Stimulus: assert i_rst after 3 transfers.
  - Response: o_writeValid=0 the next cycle; a subsequent activate restarts cleanly.
  - Stimulus: i_activate pulsed during FILL.
  - Response: the pulse is ignored.
